// File: rtl/multi_linked_list_pkg.sv
// Shared types for the multi-list linked-list block: operation codes,
// controller states and a small width helper for the list selector.
package multi_linked_list_pkg;

    typedef enum logic [2:0] {
        OP_READ_IDX   = 3'd0,
        OP_INSERT_IDX = 3'd1,
        OP_DELETE_VAL = 3'd2,
        OP_DELETE_IDX = 3'd3,
        OP_FIND_VAL   = 3'd4,
        OP_CLEAR_LIST = 3'd5
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WALK,
        ST_EXEC,
        ST_CLEAR,
        ST_DONE
    } state_e;

    // A single list still needs a one-bit selector port.
    function automatic int list_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/multi_linked_list_free_alloc.sv
// Free-node allocator for the shared pool: finds the lowest-numbered
// free node and counts how many nodes are still unallocated.
module ll_free_alloc
    import multi_linked_list_pkg::*;
#(
    parameter int MAX_NODE = 8,
    localparam int PTR_W   = $clog2(MAX_NODE + 1)
) (
    input  logic [MAX_NODE-1:0] valid_vec,
    output logic [PTR_W-1:0]    alloc_idx,
    output logic [PTR_W-1:0]    free_count,
    output logic                pool_full,
    output logic                pool_empty
);

    // Scan from the top down so the last free slot seen is the lowest one.
    always_comb begin
        alloc_idx  = PTR_W'(MAX_NODE);
        free_count = '0;
        for (int i = MAX_NODE - 1; i >= 0; i--) begin
            if (!valid_vec[i]) begin
                alloc_idx  = PTR_W'(i);
                free_count = free_count + PTR_W'(1);
            end
        end
    end

    assign pool_full  = (free_count == '0);
    assign pool_empty = (free_count == PTR_W'(MAX_NODE));

endmodule

// File: rtl/multi_linked_list.sv
// Several singly linked lists sharing one node pool. Each list keeps a
// head, tail and length; index and value operations walk one node per cycle,
// while push_front / push_back complete without walking.
module multi_linked_list
    import multi_linked_list_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int MAX_NODE   = 8,
    parameter int NUM_LISTS  = 4,
    localparam int PTR_W     = $clog2(MAX_NODE + 1),
    localparam int LIST_W    = list_width(NUM_LISTS)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       op_start,
    input  logic [2:0]                 op,
    input  logic [LIST_W-1:0]          list_id,
    input  logic [PTR_W-1:0]           idx_in,
    input  logic [DATA_WIDTH-1:0]      data_in,
    output logic                       ready,
    output logic                       op_done,
    output logic                       fault,
    output logic [DATA_WIDTH-1:0]      data_out,
    output logic [PTR_W-1:0]           idx_out,
    output logic [NUM_LISTS*PTR_W-1:0] lengths,
    output logic [PTR_W-1:0]           free_count,
    output logic                       pool_full,
    output logic                       pool_empty
);

    localparam int               NODE_W   = $clog2(MAX_NODE);
    localparam logic [PTR_W-1:0] NULL_PTR = PTR_W'(MAX_NODE);

    // Node layout depends on the module parameters, so it lives here.
    typedef struct packed {
        logic [DATA_WIDTH-1:0] data;
        logic [PTR_W-1:0]      next;
        logic                  valid;
    } node_t;

    state_e                state_q, state_d;
    op_e                   op_q, op_d;
    logic [LIST_W-1:0]     list_q, list_d;
    logic [PTR_W-1:0]      idx_q, idx_d;
    logic [DATA_WIDTH-1:0] key_q, key_d;
    logic [PTR_W-1:0]      cur_q, cur_d;
    logic [PTR_W-1:0]      prev_q, prev_d;
    logic [PTR_W-1:0]      cnt_q, cnt_d;
    logic                  fault_q, fault_d;
    logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
    logic [PTR_W-1:0]      idx_out_q, idx_out_d;

    node_t                 nodes_q [MAX_NODE];
    node_t                 nodes_d [MAX_NODE];
    logic [PTR_W-1:0]      head_q  [NUM_LISTS];
    logic [PTR_W-1:0]      head_d  [NUM_LISTS];
    logic [PTR_W-1:0]      tail_q  [NUM_LISTS];
    logic [PTR_W-1:0]      tail_d  [NUM_LISTS];
    logic [PTR_W-1:0]      len_q   [NUM_LISTS];
    logic [PTR_W-1:0]      len_d   [NUM_LISTS];

    logic [MAX_NODE-1:0]   valid_vec;
    logic [PTR_W-1:0]      alloc_ptr;
    logic [NODE_W-1:0]     alloc_i, cur_i, prev_i, tail_i;
    logic                  list_ok;
    logic [PTR_W-1:0]      sel_len, sel_head;
    node_t                 cur_node;
    logic                  hit;

    ll_free_alloc #(.MAX_NODE(MAX_NODE)) u_free_alloc (
        .valid_vec  (valid_vec),
        .alloc_idx  (alloc_ptr),
        .free_count (free_count),
        .pool_full  (pool_full),
        .pool_empty (pool_empty)
    );

    // Gather per-node valid bits and narrow pointers to pool indices.
    always_comb begin
        for (int i = 0; i < MAX_NODE; i++) begin
            valid_vec[i] = nodes_q[i].valid;
        end
        alloc_i  = alloc_ptr[NODE_W-1:0];
        cur_i    = cur_q[NODE_W-1:0];
        prev_i   = prev_q[NODE_W-1:0];
        tail_i   = tail_q[list_q][NODE_W-1:0];
        cur_node = nodes_q[cur_i];
        list_ok  = (int'(list_id) < NUM_LISTS);
        sel_len  = list_ok ? len_q[list_id]  : '0;
        sel_head = list_ok ? head_q[list_id] : NULL_PTR;
    end

    // Controller: accept, walk, link/unlink, clear and report completion.
    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        list_d     = list_q;
        idx_d      = idx_q;
        key_d      = key_q;
        cur_d      = cur_q;
        prev_d     = prev_q;
        cnt_d      = cnt_q;
        fault_d    = fault_q;
        data_out_d = data_out_q;
        idx_out_d  = idx_out_q;
        nodes_d    = nodes_q;
        head_d     = head_q;
        tail_d     = tail_q;
        len_d      = len_q;
        hit        = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (op_start) begin
                    list_d  = list_id;
                    idx_d   = idx_in;
                    key_d   = data_in;
                    cur_d   = sel_head;
                    prev_d  = NULL_PTR;
                    cnt_d   = '0;
                    fault_d = 1'b0;
                    if (!list_ok) begin
                        fault_d = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        case (op)
                            OP_READ_IDX, OP_DELETE_IDX: begin
                                op_d = op_e'(op);
                                if (idx_in >= sel_len) begin
                                    fault_d = 1'b1;
                                    state_d = ST_DONE;
                                end else begin
                                    state_d = ST_WALK;
                                end
                            end
                            OP_INSERT_IDX: begin
                                op_d = op_e'(op);
                                if (pool_full) begin
                                    fault_d = 1'b1;
                                    state_d = ST_DONE;
                                end else if (idx_in == '0 || idx_in >= sel_len) begin
                                    state_d = ST_EXEC;
                                end else begin
                                    state_d = ST_WALK;
                                end
                            end
                            OP_DELETE_VAL, OP_FIND_VAL: begin
                                op_d = op_e'(op);
                                if (sel_len == '0) begin
                                    fault_d = 1'b1;
                                    state_d = ST_DONE;
                                end else begin
                                    state_d = ST_WALK;
                                end
                            end
                            OP_CLEAR_LIST: begin
                                op_d    = op_e'(op);
                                state_d = ST_CLEAR;
                            end
                            default: begin
                                fault_d = 1'b1;
                                state_d = ST_DONE;
                            end
                        endcase
                    end
                end
            end

            ST_EXEC: begin
                nodes_d[alloc_i].data  = key_q;
                nodes_d[alloc_i].valid = 1'b1;
                if (len_q[list_q] == '0) begin
                    nodes_d[alloc_i].next = NULL_PTR;
                    head_d[list_q]        = alloc_ptr;
                    tail_d[list_q]        = alloc_ptr;
                end else if (idx_q == '0) begin
                    nodes_d[alloc_i].next = head_q[list_q];
                    head_d[list_q]        = alloc_ptr;
                end else begin
                    nodes_d[tail_i].next  = alloc_ptr;
                    nodes_d[alloc_i].next = NULL_PTR;
                    tail_d[list_q]        = alloc_ptr;
                end
                len_d[list_q] = len_q[list_q] + PTR_W'(1);
                state_d       = ST_DONE;
            end

            ST_WALK: begin
                if (op_q == OP_FIND_VAL || op_q == OP_DELETE_VAL) begin
                    hit = (cur_node.data == key_q);
                end else begin
                    hit = (cnt_q == idx_q);
                end
                if (cur_q == NULL_PTR) begin
                    fault_d = 1'b1;
                    state_d = ST_DONE;
                end else if (hit) begin
                    state_d = ST_DONE;
                    if (op_q == OP_INSERT_IDX) begin
                        nodes_d[alloc_i].data  = key_q;
                        nodes_d[alloc_i].next  = cur_q;
                        nodes_d[alloc_i].valid = 1'b1;
                        nodes_d[prev_i].next   = alloc_ptr;
                        len_d[list_q]          = len_q[list_q] + PTR_W'(1);
                    end else begin
                        data_out_d = cur_node.data;
                        if (op_q == OP_FIND_VAL || op_q == OP_DELETE_VAL) begin
                            idx_out_d = cnt_q;
                        end
                        if (op_q == OP_DELETE_IDX || op_q == OP_DELETE_VAL) begin
                            nodes_d[cur_i].valid = 1'b0;
                            nodes_d[cur_i].next  = NULL_PTR;
                            if (prev_q == NULL_PTR) begin
                                head_d[list_q] = cur_node.next;
                            end else begin
                                nodes_d[prev_i].next = cur_node.next;
                            end
                            if (cur_q == tail_q[list_q]) begin
                                tail_d[list_q] = prev_q;
                            end
                            len_d[list_q] = len_q[list_q] - PTR_W'(1);
                        end
                    end
                end else if (cur_node.next == NULL_PTR) begin
                    fault_d = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    prev_d = cur_q;
                    cur_d  = cur_node.next;
                    cnt_d  = cnt_q + PTR_W'(1);
                end
            end

            ST_CLEAR: begin
                if (cur_q == NULL_PTR) begin
                    head_d[list_q] = NULL_PTR;
                    tail_d[list_q] = NULL_PTR;
                    state_d        = ST_DONE;
                end else begin
                    nodes_d[cur_i].valid = 1'b0;
                    nodes_d[cur_i].next  = NULL_PTR;
                    head_d[list_q]       = cur_node.next;
                    cur_d                = cur_node.next;
                    len_d[list_q]        = len_q[list_q] - PTR_W'(1);
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, pool and per-list bookkeeping registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            op_q       <= OP_READ_IDX;
            list_q     <= '0;
            idx_q      <= '0;
            key_q      <= '0;
            cur_q      <= NULL_PTR;
            prev_q     <= NULL_PTR;
            cnt_q      <= '0;
            fault_q    <= 1'b0;
            data_out_q <= '0;
            idx_out_q  <= '0;
            for (int i = 0; i < MAX_NODE; i++) begin
                nodes_q[i] <= '{data: '0, next: NULL_PTR, valid: 1'b0};
            end
            for (int l = 0; l < NUM_LISTS; l++) begin
                head_q[l] <= NULL_PTR;
                tail_q[l] <= NULL_PTR;
                len_q[l]  <= '0;
            end
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            list_q     <= list_d;
            idx_q      <= idx_d;
            key_q      <= key_d;
            cur_q      <= cur_d;
            prev_q     <= prev_d;
            cnt_q      <= cnt_d;
            fault_q    <= fault_d;
            data_out_q <= data_out_d;
            idx_out_q  <= idx_out_d;
            nodes_q    <= nodes_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            len_q      <= len_d;
        end
    end

    // Pack the per-list lengths onto the flat output bus.
    always_comb begin
        for (int l = 0; l < NUM_LISTS; l++) begin
            lengths[l*PTR_W +: PTR_W] = len_q[l];
        end
    end

    assign ready    = (state_q == ST_IDLE);
    assign op_done  = (state_q == ST_DONE);
    assign fault    = op_done & fault_q;
    assign data_out = data_out_q;
    assign idx_out  = idx_out_q;

endmodule

// File: tb/tb_multi_linked_list.sv
// Directed bench for multi_linked_list: a table of operations with
// hand-computed latency, fault, payload, index, length and pool counts,
// followed by hand-written busy-ignore and mid-walk reset sequences.
module tb_multi_linked_list;

    logic       clk = 1'b0;
    logic       rst;
    logic       op_start;
    logic [2:0] op;
    logic [1:0] list_id;
    logic [3:0] idx_in;
    logic [7:0] data_in;
    logic       ready;
    logic       op_done;
    logic       fault;
    logic [7:0] data_out;
    logic [3:0] idx_out;
    logic [15:0] lengths;
    logic [3:0] free_count;
    logic       pool_full;
    logic       pool_empty;

    int checks   = 0;
    int failures = 0;

    int         lat;
    logic       got_fault;
    logic [7:0] got_data;
    logic [3:0] got_idx;

    typedef struct {
        int op;
        int list;
        int idx;
        int data;
        int lat;
        int flt;
        bit chk_data;
        int exp_data;
        bit chk_idx;
        int exp_idx;
        int exp_len;
        int exp_free;
    } vec_t;

    vec_t vecs[$];

    multi_linked_list #(
        .DATA_WIDTH (8),
        .MAX_NODE   (8),
        .NUM_LISTS  (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .op_start   (op_start),
        .op         (op),
        .list_id    (list_id),
        .idx_in     (idx_in),
        .data_in    (data_in),
        .ready      (ready),
        .op_done    (op_done),
        .fault      (fault),
        .data_out   (data_out),
        .idx_out    (idx_out),
        .lengths    (lengths),
        .free_count (free_count),
        .pool_full  (pool_full),
        .pool_empty (pool_empty)
    );

    // Free-running 10-unit clock.
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Issue one request and wait (bounded) for op_done; latency counts
    // clock edges from the accepting edge, so an immediate fault gives 1.
    task automatic applyStimulus(input int o, input int l, input int i, input int d, output int latency);
        op       = 3'(o);
        list_id  = 2'(l);
        idx_in   = 4'(i);
        data_in  = 8'(d);
        op_start = 1'b1;
        latency  = 0;
        do begin
            @(posedge clk);
            #1;
            op_start = 1'b0;
            latency++;
        end while (!op_done && latency < 60);
        if (!op_done) begin
            checks++;
            failures++;
            $display("[TB] FAIL op_timeout: got no op_done, expected op_done within 60 cycles");
        end
        got_fault = fault;
        got_data  = data_out;
        got_idx   = idx_out;
        @(posedge clk);
        #1;
    endtask

    task automatic addVec(input int o, input int l, input int i, input int d, input int lt, input int f,
                          input bit cd, input int ed, input bit ci, input int ei, input int el, input int ef);
        vec_t v;
        v.op = o; v.list = l; v.idx = i; v.data = d; v.lat = lt; v.flt = f;
        v.chk_data = cd; v.exp_data = ed; v.chk_idx = ci; v.exp_idx = ei;
        v.exp_len = el; v.exp_free = ef;
        vecs.push_back(v);
    endtask

    function automatic int sumLengths();
        int s = 0;
        for (int l = 0; l < 4; l++) s += int'(lengths[l*4 +: 4]);
        return s;
    endfunction

    // Guard against a hung design: report and stop hard.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    // Main directed sequence.
    initial begin
        bit seen_done;

        rst = 1'b1; op_start = 1'b0; op = '0; list_id = '0; idx_in = '0; data_in = '0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_ready",      ready,      1);
        checkOutput("rst_op_done",    op_done,    0);
        checkOutput("rst_fault",      fault,      0);
        checkOutput("rst_data_out",   data_out,   0);
        checkOutput("rst_idx_out",    idx_out,    0);
        checkOutput("rst_lengths",    lengths,    0);
        checkOutput("rst_free_count", free_count, 8);
        checkOutput("rst_pool_empty", pool_empty, 1);
        checkOutput("rst_pool_full",  pool_full,  0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // op: 0 READ 1 INSERT 2 DEL_VAL 3 DEL_IDX 4 FIND 5 CLEAR 6 reserved
        //     op l  idx data lat flt cd  data ci idx len free
        addVec(1, 0, 15, 10, 2, 0, 0,  0, 0, 0, 1, 7);
        addVec(1, 0, 15, 20, 2, 0, 0,  0, 0, 0, 2, 6);
        addVec(1, 0, 15, 30, 2, 0, 0,  0, 0, 0, 3, 5);
        addVec(0, 0,  2,  0, 4, 0, 1, 30, 0, 0, 3, 5);
        addVec(1, 0,  1, 15, 3, 0, 0,  0, 0, 0, 4, 4);
        addVec(0, 0,  0,  0, 2, 0, 1, 10, 0, 0, 4, 4);
        addVec(0, 0,  1,  0, 3, 0, 1, 15, 0, 0, 4, 4);
        addVec(0, 0,  2,  0, 4, 0, 1, 20, 0, 0, 4, 4);
        addVec(0, 0,  3,  0, 5, 0, 1, 30, 0, 0, 4, 4);
        addVec(1, 1, 15,  1, 2, 0, 0,  0, 0, 0, 1, 3);
        addVec(1, 2, 15,  3, 2, 0, 0,  0, 0, 0, 1, 2);
        addVec(1, 1, 15,  2, 2, 0, 0,  0, 0, 0, 2, 1);
        addVec(1, 2, 15,  4, 2, 0, 0,  0, 0, 0, 2, 0);
        addVec(0, 1,  0,  0, 2, 0, 1,  1, 0, 0, 2, 0);
        addVec(0, 1,  1,  0, 3, 0, 1,  2, 0, 0, 2, 0);
        addVec(0, 2,  0,  0, 2, 0, 1,  3, 0, 0, 2, 0);
        addVec(0, 2,  1,  0, 3, 0, 1,  4, 0, 0, 2, 0);
        addVec(1, 3,  0,  5, 1, 1, 0,  0, 0, 0, 0, 0);
        addVec(2, 0,  0, 20, 4, 0, 1, 20, 1, 2, 3, 1);
        addVec(2, 0,  0, 99, 4, 1, 0,  0, 0, 0, 3, 1);
        addVec(3, 0,  5,  0, 1, 1, 0,  0, 0, 0, 3, 1);
        addVec(4, 0,  0, 30, 4, 0, 1, 30, 1, 2, 3, 1);
        addVec(5, 0,  0,  0, 5, 0, 0,  0, 0, 0, 0, 4);
        addVec(1, 1, 15,  9, 2, 0, 0,  0, 0, 0, 3, 3);
        addVec(0, 1,  2,  0, 4, 0, 1,  9, 0, 0, 3, 3);
        addVec(1, 1,  0,  8, 2, 0, 0,  0, 0, 0, 4, 2);
        addVec(0, 1,  0,  0, 2, 0, 1,  8, 0, 0, 4, 2);
        addVec(0, 1,  3,  0, 5, 0, 1,  9, 0, 0, 4, 2);
        addVec(3, 1,  3,  0, 5, 0, 1,  9, 0, 0, 3, 3);
        addVec(1, 1, 15, 11, 2, 0, 0,  0, 0, 0, 4, 2);
        addVec(0, 1,  3,  0, 5, 0, 1, 11, 0, 0, 4, 2);
        addVec(3, 2,  0,  0, 2, 0, 1,  3, 0, 0, 1, 3);
        addVec(3, 2,  0,  0, 2, 0, 1,  4, 0, 0, 0, 4);
        addVec(4, 2,  0,  4, 1, 1, 0,  0, 0, 0, 0, 4);
        addVec(1, 2, 15,  6, 2, 0, 0,  0, 0, 0, 1, 3);
        addVec(0, 2,  0,  0, 2, 0, 1,  6, 0, 0, 1, 3);
        addVec(5, 3,  0,  0, 2, 0, 0,  0, 0, 0, 0, 3);
        addVec(6, 0,  0,  0, 1, 1, 0,  0, 0, 0, 0, 3);
        addVec(4, 1,  0,  2, 4, 0, 1,  2, 1, 2, 4, 3);

        foreach (vecs[n]) begin
            applyStimulus(vecs[n].op, vecs[n].list, vecs[n].idx, vecs[n].data, lat);
            checkOutput($sformatf("v%0d_latency", n), lat, vecs[n].lat);
            checkOutput($sformatf("v%0d_fault", n), got_fault, vecs[n].flt);
            if (vecs[n].chk_data) checkOutput($sformatf("v%0d_data_out", n), got_data, vecs[n].exp_data);
            if (vecs[n].chk_idx)  checkOutput($sformatf("v%0d_idx_out", n), got_idx, vecs[n].exp_idx);
            checkOutput($sformatf("v%0d_length", n), lengths[vecs[n].list*4 +: 4], vecs[n].exp_len);
            checkOutput($sformatf("v%0d_free_count", n), free_count, vecs[n].exp_free);
            checkOutput($sformatf("v%0d_pool_full", n), pool_full, (vecs[n].exp_free == 0));
            checkOutput($sformatf("v%0d_pool_empty", n), pool_empty, (vecs[n].exp_free == 8));
            checkOutput($sformatf("v%0d_node_sum", n), sumLengths() + int'(free_count), 8);
        end

        // Busy: a second request while walking must be ignored.
        op = 3'd0; list_id = 2'd1; idx_in = 4'd3; data_in = 8'd0; op_start = 1'b1;
        @(posedge clk);
        #1;
        lat = 1;
        checkOutput("busy_ready_low", ready, 0);
        op = 3'd5;
        while (!op_done && lat < 60) begin
            @(posedge clk);
            #1;
            lat++;
        end
        op_start = 1'b0;
        checkOutput("busy_latency", lat, 5);
        checkOutput("busy_data_out", data_out, 11);
        checkOutput("busy_length1", lengths[7:4], 4);
        @(posedge clk);
        #1;
        checkOutput("busy_ready_back", ready, 1);
        checkOutput("busy_no_clear", lengths[7:4], 4);

        // Reset in the middle of a walk aborts with no completion.
        op = 3'd0; list_id = 2'd1; idx_in = 4'd3; op_start = 1'b1;
        @(posedge clk);
        #1;
        op_start = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        checkOutput("midrst_op_done",  op_done,    0);
        checkOutput("midrst_ready",    ready,      1);
        checkOutput("midrst_lengths",  lengths,    0);
        checkOutput("midrst_free",     free_count, 8);
        checkOutput("midrst_empty",    pool_empty, 1);
        checkOutput("midrst_data_out", data_out,   0);
        checkOutput("midrst_idx_out",  idx_out,    0);
        seen_done = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk);
            #1;
            if (c == 1) rst = 1'b0;
            if (op_done) seen_done = 1'b1;
        end
        checkOutput("midrst_no_done", seen_done, 0);

        applyStimulus(1, 2, 15, 42, lat);
        checkOutput("post_rst_ins_latency", lat, 2);
        checkOutput("post_rst_ins_free", free_count, 7);
        applyStimulus(0, 2, 0, 0, lat);
        checkOutput("post_rst_read_data", got_data, 42);
        checkOutput("post_rst_read_latency", lat, 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
